// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-requester (CPU, DMA) round-robin arbiter in front of a single memory
//   port with a fixed access latency of MEM_LAT cycles.
//
//   Each transaction runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP (1 cycle).
//   The winner's we/addr/wdata are latched when IDLE is left, so later
//   changes on either requester's inputs cannot disturb the access. Read
//   data is captured in the final ACCESS cycle into the winner's own rdata
//   register and held there until that requester's next read completes.
//
// Ports
//   clk, reset               clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata    CPU request side (req held until cpu_ack)
//   cpu_rdata, cpu_ack       CPU registered read data, one-cycle ack pulse
//   dma_*                    identical port set for the DMA requester
//   mem_en/we/addr/wdata     memory command, valid only during ACCESS
//   mem_rdata                memory read data, valid in final ACCESS cycle
//   grant                    current owner: 00 none, 01 CPU, 10 DMA
//   busy                     high during ACCESS and RESP
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_ack,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [WIDTH-1:0] dma_addr,
    input  logic [WIDTH-1:0] dma_wdata,
    output logic [WIDTH-1:0] dma_rdata,
    output logic             dma_ack,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [1:0]       grant,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // The counter counts down to 0, so it is loaded with one less than the
    // number of ACCESS cycles.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             lastDma_q, lastDma_d;
    logic             ownerDma_q, ownerDma_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]       grant_q, grant_d;
    logic [WIDTH-1:0] cpuRdata_q, cpuRdata_d;
    logic [WIDTH-1:0] dmaRdata_q, dmaRdata_d;
    logic             cpuWins;

    // The CPU wins when it is alone, or in a conflict when the DMA was the
    // last one served. lastDma_q resets to 1 so the CPU takes the first
    // conflict after reset.
    assign cpuWins = cpu_req && (!dma_req || lastDma_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            lastDma_q  <= 1'b1;
            ownerDma_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            grant_q    <= 2'b00;
            cpuRdata_q <= '0;
            dmaRdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lastDma_q  <= lastDma_d;
            ownerDma_q <= ownerDma_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            grant_q    <= grant_d;
            cpuRdata_q <= cpuRdata_d;
            dmaRdata_q <= dmaRdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lastDma_d  = lastDma_q;
        ownerDma_d = ownerDma_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        grant_d    = grant_q;
        cpuRdata_d = cpuRdata_q;
        dmaRdata_d = dmaRdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_LOAD;
                    if (cpuWins) begin
                        ownerDma_d = 1'b0;
                        we_d       = cpu_we;
                        addr_d     = cpu_addr;
                        wdata_d    = cpu_wdata;
                        grant_d    = 2'b01;
                    end else begin
                        ownerDma_d = 1'b1;
                        we_d       = dma_we;
                        addr_d     = dma_addr;
                        wdata_d    = dma_wdata;
                        grant_d    = 2'b10;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Final access cycle: memory read data is valid now.
                    state_d   = RESP;
                    lastDma_d = ownerDma_q;
                    if (!we_q) begin
                        if (ownerDma_q) begin
                            dmaRdata_d = mem_rdata;
                        end else begin
                            cpuRdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state_q == RESP) && !ownerDma_q;
    assign dma_ack   = (state_q == RESP) && ownerDma_q;
    assign busy      = (state_q == ACCESS) || (state_q == RESP);
    assign grant     = grant_q;
    assign cpu_rdata = cpuRdata_q;
    assign dma_rdata = dmaRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed testbench for mem_arbiter. The main instance uses MEM_LAT=2;
//   two extra instances with MEM_LAT=1 and MEM_LAT=15 cover the latency
//   extremes. All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        reset;

    logic        cpuReq, cpuWe, dmaReq, dmaWe;
    logic [31:0] cpuAddr, cpuWdata, dmaAddr, dmaWdata, memRdata;
    logic [31:0] cpuRdata, dmaRdata, memAddr, memWdata;
    logic        cpuAck, dmaAck, memEn, memWe, busy;
    logic [1:0]  grant;

    logic        r1Req, r15Req;
    logic [31:0] r1CpuRdata, r1DmaRdata, r1MemAddr, r1MemWdata;
    logic [31:0] r15CpuRdata, r15DmaRdata, r15MemAddr, r15MemWdata;
    logic        r1CpuAck, r1DmaAck, r1MemEn, r1MemWe, r1Busy;
    logic        r15CpuAck, r15DmaAck, r15MemEn, r15MemWe, r15Busy;
    logic [1:0]  r1Grant, r15Grant;

    int          checkCount;
    int          passCount;

    mem_arbiter #(.WIDTH(32), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_rdata(cpuRdata), .cpu_ack(cpuAck),
        .dma_req(dmaReq), .dma_we(dmaWe), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
        .dma_rdata(dmaRdata), .dma_ack(dmaAck),
        .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .grant(grant), .busy(busy)
    );

    mem_arbiter #(.WIDTH(32), .MEM_LAT(1)) dutLat1 (
        .clk(clk), .reset(reset),
        .cpu_req(r1Req), .cpu_we(1'b0), .cpu_addr(32'h0000_0004), .cpu_wdata(32'h0),
        .cpu_rdata(r1CpuRdata), .cpu_ack(r1CpuAck),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
        .dma_rdata(r1DmaRdata), .dma_ack(r1DmaAck),
        .mem_en(r1MemEn), .mem_we(r1MemWe), .mem_addr(r1MemAddr), .mem_wdata(r1MemWdata),
        .mem_rdata(32'hA5A5_0001), .grant(r1Grant), .busy(r1Busy)
    );

    mem_arbiter #(.WIDTH(32), .MEM_LAT(15)) dutLat15 (
        .clk(clk), .reset(reset),
        .cpu_req(r15Req), .cpu_we(1'b0), .cpu_addr(32'h0000_0008), .cpu_wdata(32'h0),
        .cpu_rdata(r15CpuRdata), .cpu_ack(r15CpuAck),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
        .dma_rdata(r15DmaRdata), .dma_ack(r15DmaAck),
        .mem_en(r15MemEn), .mem_we(r15MemWe), .mem_addr(r15MemAddr), .mem_wdata(r15MemWdata),
        .mem_rdata(32'hA5A5_000F), .grant(r15Grant), .busy(r15Busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                                 input logic [31:0] cData, input logic dReq, input logic dWe,
                                 input logic [31:0] dAddr, input logic [31:0] dData);
        cpuReq   = cReq;
        cpuWe    = cWe;
        cpuAddr  = cAddr;
        cpuWdata = cData;
        dmaReq   = dReq;
        dmaWe    = dWe;
        dmaAddr  = dAddr;
        dmaWdata = dData;
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic ackOf(input int which);
        case (which)
            0:       return cpuAck;
            1:       return dmaAck;
            2:       return r1CpuAck;
            default: return r15CpuAck;
        endcase
    endfunction

    // Counts cycles from the request edge until the selected ack is seen,
    // giving up after 'bound' cycles.
    task automatic waitAck(input int which, input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ackOf(which) && n < bound);
    endtask

    int  lat;
    logic ackSeen;

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset      = 1'b0;
        r1Req      = 1'b0;
        r15Req     = 1'b0;
        memRdata   = 32'h0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset values
        tick();
        tick();
        checkOutput("rst_grant", {30'd0, grant}, 32'h0);
        checkOutput("rst_busy", {31'd0, busy}, 32'h0);
        checkOutput("rst_mem_en", {31'd0, memEn}, 32'h0);
        checkOutput("rst_mem_we", {31'd0, memWe}, 32'h0);
        checkOutput("rst_acks", {30'd0, cpuAck, dmaAck}, 32'h0);
        checkOutput("rst_cpu_rdata", cpuRdata, 32'h0);
        checkOutput("rst_dma_rdata", dmaRdata, 32'h0);
        checkOutput("rst_mem_addr", memAddr, 32'h0);
        checkOutput("rst_mem_wdata", memWdata, 32'h0);
        reset = 1'b1;

        // CPU read at 0x40 with mid-access address churn
        memRdata = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rd_acc1_en", {31'd0, memEn}, 32'h1);
        checkOutput("rd_acc1_we", {31'd0, memWe}, 32'h0);
        checkOutput("rd_acc1_addr", memAddr, 32'h40);
        checkOutput("rd_acc1_grant", {30'd0, grant}, 32'h1);
        checkOutput("rd_acc1_busy", {31'd0, busy}, 32'h1);
        checkOutput("rd_acc1_ack", {31'd0, cpuAck}, 32'h0);
        cpuAddr = 32'h44;
        tick();
        checkOutput("rd_acc2_en", {31'd0, memEn}, 32'h1);
        checkOutput("rd_churn_addr", memAddr, 32'h40);
        tick();
        checkOutput("rd_resp_en", {31'd0, memEn}, 32'h0);
        checkOutput("rd_resp_cpu_ack", {31'd0, cpuAck}, 32'h1);
        checkOutput("rd_resp_dma_ack", {31'd0, dmaAck}, 32'h0);
        checkOutput("rd_cpu_rdata", cpuRdata, 32'hDEAD_BEEF);
        checkOutput("rd_dma_rdata", dmaRdata, 32'h0);
        checkOutput("rd_resp_busy", {31'd0, busy}, 32'h1);
        cpuReq = 1'b0;
        tick();
        checkOutput("rd_idle_ack", {31'd0, cpuAck}, 32'h0);
        checkOutput("rd_idle_grant", {30'd0, grant}, 32'h0);
        checkOutput("rd_idle_busy", {31'd0, busy}, 32'h0);
        checkOutput("rd_hold_rdata", cpuRdata, 32'hDEAD_BEEF);

        // DMA write of 0x12345678 to 0x80; memory data changes must not land
        memRdata = 32'hCAFE_F00D;
        applyStimulus(1'b0, 1'b0, 32'h44, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234_5678);
        tick();
        checkOutput("wr_acc1_en", {31'd0, memEn}, 32'h1);
        checkOutput("wr_acc1_we", {31'd0, memWe}, 32'h1);
        checkOutput("wr_acc1_addr", memAddr, 32'h80);
        checkOutput("wr_acc1_wdata", memWdata, 32'h1234_5678);
        checkOutput("wr_acc1_grant", {30'd0, grant}, 32'h2);
        dmaWdata = 32'hFFFF_FFFF;
        tick();
        checkOutput("wr_acc2_we", {31'd0, memWe}, 32'h1);
        checkOutput("wr_acc2_wdata", memWdata, 32'h1234_5678);
        tick();
        checkOutput("wr_resp_dma_ack", {31'd0, dmaAck}, 32'h1);
        checkOutput("wr_resp_cpu_ack", {31'd0, cpuAck}, 32'h0);
        checkOutput("wr_resp_we", {31'd0, memWe}, 32'h0);
        checkOutput("wr_cpu_rdata", cpuRdata, 32'hDEAD_BEEF);
        checkOutput("wr_dma_rdata", dmaRdata, 32'h0);
        dmaReq = 1'b0;
        tick();
        checkOutput("wr_idle_ack", {31'd0, dmaAck}, 32'h0);

        // DMA read: only the DMA rdata register moves
        memRdata = 32'h0BAD_F00D;
        applyStimulus(1'b0, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0);
        waitAck(1, 20, lat);
        checkOutput("drd_latency", lat, 32'd3);
        checkOutput("drd_dma_rdata", dmaRdata, 32'h0BAD_F00D);
        checkOutput("drd_cpu_rdata", cpuRdata, 32'hDEAD_BEEF);
        dmaReq = 1'b0;
        tick();

        // Conflict after reset: CPU, then DMA, then CPU while both held
        doReset();
        memRdata = 32'h1111_1111;
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        checkOutput("cf1_grant", {30'd0, grant}, 32'h1);
        checkOutput("cf1_addr", memAddr, 32'h10);
        tick();
        tick();
        checkOutput("cf1_cpu_ack", {31'd0, cpuAck}, 32'h1);
        checkOutput("cf1_dma_ack", {31'd0, dmaAck}, 32'h0);
        tick();
        checkOutput("cf_idle_grant", {30'd0, grant}, 32'h0);
        checkOutput("cf_idle_busy", {31'd0, busy}, 32'h0);
        tick();
        checkOutput("cf2_grant", {30'd0, grant}, 32'h2);
        checkOutput("cf2_addr", memAddr, 32'h20);
        tick();
        tick();
        checkOutput("cf2_dma_ack", {31'd0, dmaAck}, 32'h1);
        checkOutput("cf2_cpu_ack", {31'd0, cpuAck}, 32'h0);
        checkOutput("cf2_dma_rdata", dmaRdata, 32'h1111_1111);
        tick();
        tick();
        checkOutput("cf3_grant", {30'd0, grant}, 32'h1);
        // Dropping both requests mid-access must not abort it
        cpuReq = 1'b0;
        dmaReq = 1'b0;
        tick();
        tick();
        checkOutput("cf3_cpu_ack", {31'd0, cpuAck}, 32'h1);
        tick();
        checkOutput("cf3_idle_busy", {31'd0, busy}, 32'h0);

        // Abort: reset in the first ACCESS cycle
        memRdata = 32'h5555_5555;
        applyStimulus(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("ab_acc_en", {31'd0, memEn}, 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("ab_en", {31'd0, memEn}, 32'h0);
        checkOutput("ab_busy", {31'd0, busy}, 32'h0);
        checkOutput("ab_grant", {30'd0, grant}, 32'h0);
        checkOutput("ab_mem_addr", memAddr, 32'h0);
        checkOutput("ab_cpu_rdata", cpuRdata, 32'h0);
        cpuReq = 1'b0;
        tick();
        reset = 1'b1;
        ackSeen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            ackSeen = ackSeen | cpuAck | dmaAck;
        end
        checkOutput("ab_no_ack", {31'd0, ackSeen}, 32'h0);

        // Latency extremes
        r1Req = 1'b1;
        waitAck(2, 40, lat);
        r1Req = 1'b0;
        checkOutput("lat1_cycles", lat, 32'd2);
        checkOutput("lat1_rdata", r1CpuRdata, 32'hA5A5_0001);
        r15Req = 1'b1;
        waitAck(3, 40, lat);
        r15Req = 1'b0;
        checkOutput("lat15_cycles", lat, 32'd16);
        checkOutput("lat15_rdata", r15CpuRdata, 32'hA5A5_000F);
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the address and data width.
REQ-002 The block SHALL have parameter MEM_LAT, default 2, giving the memory access cycles; the legal range is 1..15.

Interface
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-005 cpu_req  in  1  CPU access request; held until cpu_ack.
REQ-006 cpu_we  in  1  CPU write enable (1=write, 0=read).
REQ-007 cpu_addr, cpu_wdata  in  WIDTH  CPU address and write data.
REQ-008 cpu_rdata  out  WIDTH  CPU read data; registered.
REQ-009 cpu_ack  out  1  one-cycle completion pulse for the CPU.
REQ-010 dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  SHALL match the CPU port signals in direction and width, for the DMA requester.
REQ-011 mem_en  out  1  memory enable.
REQ-012 mem_we  out  1  memory write enable.
REQ-013 mem_addr, mem_wdata  out  WIDTH  memory address and write data.
REQ-014 mem_rdata  in  WIDTH  memory read data, valid in the final access cycle.
REQ-015 grant  out  2  owner of the current access: 00 none, 01 CPU, 10 DMA.
REQ-016 busy  out  1  high in the ACCESS and RESP states.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ACCESS and RESP.
REQ-018 IDLE SHALL go to ACCESS if any req=1; otherwise the FSM SHALL stay in IDLE.
REQ-019 On leaving IDLE, the block SHALL latch the winner's we, addr and wdata into internal registers and SHALL set grant.
REQ-020 Arbitration with one requester active: the active requester SHALL win.
REQ-021 Arbitration with both requesters active: the requester other than last_served SHALL win (round-robin).
REQ-022 last_served SHALL update on every entry to RESP.
REQ-023 ACCESS SHALL last exactly MEM_LAT cycles, timed by a 4-bit down-counter loaded with MEM_LAT-1.
REQ-024 ACCESS SHALL go to RESP when the counter reaches 0.
REQ-025 During ACCESS, mem_en SHALL be 1 and mem_we, mem_addr and mem_wdata SHALL come from the latched registers.
REQ-026 Outside ACCESS, mem_en and mem_we SHALL be 0.
REQ-027 In the final ACCESS cycle of a read, the block SHALL capture mem_rdata into the winner's rdata register.
REQ-028 The other requester's rdata register SHALL be unchanged by that capture.
REQ-029 A write SHALL leave both rdata registers unchanged.
REQ-030 RESP SHALL last 1 cycle and SHALL assert the winner's ack only.
REQ-031 RESP SHALL always go to IDLE.
REQ-032 grant SHALL return to 00 in IDLE.
REQ-033 Latency: with req sampled in IDLE at cycle t, ack SHALL be high in cycle t+MEM_LAT+1.
REQ-034 The rdata value SHALL be valid in the ack cycle and SHALL hold until that requester's next read completes.
REQ-035 Deasserting req during ACCESS SHALL NOT abort the access; ack SHALL still pulse.
REQ-036 A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-037 Changes to the losing requester's inputs SHALL have no effect until it is granted.
REQ-038 Changes to the winner's addr, wdata and we after the latch SHALL be ignored.
REQ-039 ack SHALL never be asserted in the same cycle as req is first sampled, and SHALL never be asserted to both requesters at once.

Reset
REQ-040 While reset=0, the block SHALL immediately, independent of clk, force state IDLE and counter 0.
REQ-041 While reset=0, last_served SHALL be DMA, so that the CPU wins the first conflict.
REQ-042 While reset=0, grant=00, busy=0, mem_en=0, mem_we=0 and both acks=0.
REQ-043 While reset=0, cpu_rdata, dma_rdata, mem_addr and mem_wdata SHALL be 0.
REQ-044 Reset asserted during ACCESS SHALL abandon the access; no ack SHALL be issued for it.
REQ-045 The first request after reset release SHALL be sampled on the first rising edge with reset=1.

Verification
REQ-046 CPU read: MEM_LAT=2, cpu_req=1, cpu_addr=0x40, mem_rdata=0xDEADBEEF -> mem_en high for 2 cycles, cpu_ack in cycle t+3, cpu_rdata=0xDEADBEEF, dma_rdata unchanged.
REQ-047 Conflict after reset: both req=1 -> CPU is served first (grant=01), then DMA (grant=10), then CPU again while both are held.
REQ-048 DMA write: dma_we=1, addr 0x80, data 0x12345678 -> mem_we=1 with those values for MEM_LAT cycles, dma_ack pulses once, both rdata unchanged.
REQ-049 Input churn: cpu_addr changed from 0x40 to 0x44 mid-ACCESS -> mem_addr stays 0x40.
REQ-050 Abort: reset=0 in the 1st ACCESS cycle -> all outputs at reset values immediately, no ack after release.
REQ-051 Parameter edge: MEM_LAT=1 and MEM_LAT=15 -> ack at t+2 and t+16 respectively.
